// File: rtl/sd_spi_arbiter_if.sv
// sd_spi_arbiter_if: requester handshakes and SD pins
// shared by the SD SPI arbiter and its users.
interface sd_spi_arbiter_if;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic       cs0, cs1;
  logic       fast0, fast1;
  logic       start0, start1;
  logic [7:0] tx0, tx1;
  logic [7:0] rx0, rx1;
  logic       done0, done1;
  logic       busy;
  logic       SD_n_CS, SD_CK, SD_DI, SD_DO;

  modport master (
    output req0, req1, cs0, cs1, fast0, fast1,
    output start0, start1, tx0, tx1, SD_DO,
    input  gnt0, gnt1, rx0, rx1, done0, done1,
    input  busy, SD_n_CS, SD_CK, SD_DI
  );

  modport slave (
    input  req0, req1, cs0, cs1, fast0, fast1,
    input  start0, start1, tx0, tx1, SD_DO,
    output gnt0, gnt1, rx0, rx1, done0, done1,
    output busy, SD_n_CS, SD_CK, SD_DI
  );
endinterface

// File: rtl/sd_spi_arbiter.sv
// sd_spi_arbiter: two-port SD SPI bus owner arbitration
// plus one shared mode-0 byte shift engine.
module sd_spi_arbiter #(
  parameter logic [7:0] C_div_slow = 8'd63,
  parameter logic [7:0] C_div_fast = 8'd1
) (
  input logic             clk_cpu,
  input logic             reset,
  sd_spi_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_e;

  arb_e       state_q, state_d;
  logic       last_q, last_d;
  logic       cs_n_q, cs_n_d;
  logic       busy_q, ck_q, di_q, own_q;
  logic [7:0] div_q, cnt_q, sh_q, rs_q;
  logic [7:0] rx0_q, rx1_q;
  logic [3:0] edge_q;
  logic       done0_q, done1_q;
  logic       acc0, acc1, acc;
  logic [7:0] div_d, tx_d;

  assign acc0 = (state_q == OWN0) && bus.start0 && !busy_q;
  assign acc1 = (state_q == OWN1) && bus.start1 && !busy_q;
  assign acc  = acc0 | acc1;

  assign div_d = (acc1 ? bus.fast1 : bus.fast0) ? C_div_fast
                                                : C_div_slow;
  assign tx_d  = acc1 ? bus.tx1 : bus.tx0;

  // arbiter next state, tie-break and chip-select source
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cs_n_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 && (!bus.req1 || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
        end else if (bus.req1) begin
          state_d = OWN1;
          last_d  = 1'b1;
        end
      end
      OWN0: begin
        cs_n_d = ~bus.cs0;
        if (!bus.req0 && !busy_q && !acc0)
          state_d = IDLE;
      end
      OWN1: begin
        cs_n_d = ~bus.cs1;
        if (!bus.req1 && !busy_q && !acc1)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // arbiter state, last owner and registered chip select
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cs_n_q  <= cs_n_d;
    end
  end

  // shift engine: toggle SD_CK every div+1 cycles,
  // sample on rise, present next bit on fall
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      busy_q  <= 1'b0;
      ck_q    <= 1'b0;
      di_q    <= 1'b1;
      own_q   <= 1'b0;
      div_q   <= 8'd0;
      cnt_q   <= 8'd0;
      sh_q    <= 8'd0;
      rs_q    <= 8'd0;
      rx0_q   <= 8'd0;
      rx1_q   <= 8'd0;
      edge_q  <= 4'd0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      if (acc) begin
        busy_q <= 1'b1;
        own_q  <= acc1;
        div_q  <= div_d;
        cnt_q  <= div_d;
        sh_q   <= tx_d;
        di_q   <= tx_d[7];
        ck_q   <= 1'b0;
        edge_q <= 4'd0;
      end else if (busy_q) begin
        if (cnt_q == 8'd0) begin
          cnt_q  <= div_q;
          ck_q   <= ~ck_q;
          edge_q <= edge_q + 4'd1;
          if (!ck_q) begin
            rs_q <= {rs_q[6:0], bus.SD_DO};
          end else if (edge_q == 4'd15) begin
            busy_q <= 1'b0;
            di_q   <= 1'b1;
            if (own_q) begin
              rx1_q   <= rs_q;
              done1_q <= 1'b1;
            end else begin
              rx0_q   <= rs_q;
              done0_q <= 1'b1;
            end
          end else begin
            sh_q <= {sh_q[6:0], 1'b0};
            di_q <= sh_q[6];
          end
        end else begin
          cnt_q <= cnt_q - 8'd1;
        end
      end
    end
  end

  assign bus.gnt0    = (state_q == OWN0);
  assign bus.gnt1    = (state_q == OWN1);
  assign bus.SD_n_CS = cs_n_q;
  assign bus.SD_CK   = ck_q;
  assign bus.SD_DI   = di_q;
  assign bus.busy    = busy_q;
  assign bus.done0   = done0_q;
  assign bus.done1   = done1_q;
  assign bus.rx0     = rx0_q;
  assign bus.rx1     = rx1_q;
endmodule

// File: doc/sd_spi_arbiter.md
# sd_spi_arbiter

Shares the single SD-card SPI port between two requesters: port 0, the boot loader that copies the BIOS image from SD card into SDRAM, and port 1, the CPU-side SD controller. The block arbitrates bus ownership, muxes chip select, and runs one byte-wide SPI mode-0 shift engine with a selectable slow (card-init) or fast clock. It sits between those requesters and the SD_n_CS / SD_CK / SD_DI / SD_DO pins in the system block.

## Interface
- C_div_slow, 63: half-period of SD_CK in slow mode is C_div_slow+1 clk_cpu cycles (50 MHz → 390 kHz).
- C_div_fast, 1: half-period of SD_CK in fast mode is C_div_fast+1 clk_cpu cycles (50 MHz → 12.5 MHz).
- Both dividers are 8 bits wide; legal values are 0..255.

- clk_cpu  in  1  sole clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high.
- req0, req1  in  1  requester wants the bus; held high for the whole transaction.
- gnt0, gnt1  out  1  requester owns the bus; at most one is high.
- cs0, cs1  in  1  requested chip select (1 = card selected); used only while granted.
- fast0, fast1  in  1  selects the divider for the next byte (1 = C_div_fast).
- start0, start1  in  1  one-cycle strobe that launches a byte.
- tx0, tx1  in  8  byte to send, sampled in the start cycle.
- rx0, rx1  out  8  received byte, valid from the done pulse until the next done on that port.
- done0, done1  out  1  one-cycle pulse when a byte completes.
- busy  out  1  shift engine is active.
- SD_n_CS  out  1  card chip select, active low.
- SD_CK  out  1  SPI clock.
- SD_DI  out  1  MOSI.
- SD_DO  in  1  MISO.

## Operation
- Arbiter states: IDLE, OWN0, OWN1. A 1-bit last-owner register resets to 1, so port 0 wins the first tie.
- IDLE:
  - If exactly one reqN is high, go to OWNN.
  - If both are high, grant the port that is not last-owner.
  - gntN is registered and goes high on the cycle of entry to OWNN.
- OWNN → IDLE when reqN is low and the engine is not busy. The grant is never preempted.
- If reqN drops mid-byte, the byte completes and doneN still pulses. The release happens on the cycle after done.
- After every release the arbiter spends at least one cycle in IDLE, so the two grants are never adjacent.
- SD_n_CS = ~csN while in OWNN; otherwise 1. Registered: it follows csN with 1 cycle of latency.
- startN is accepted only when gntN=1 and busy=0; all other starts are ignored, with no error flag.
- Shift engine: mode 0, MSB first. SD_CK idles at 0. SD_DI idles at 1 when no byte is shifting.
  - On an accepted start: latch tx and the divider (from fastN), set busy, drive SD_DI=tx[7], SD_CK=0.
  - Each half-period (div+1 cycles) toggles SD_CK.
  - Rising edge: shift SD_DO into rx[0].
  - Falling edge: present the next tx bit.
  - After the 8th falling edge: busy=0, doneN=1 for one cycle, rxN updated.
- The divider counter is 8 bits, counts down from div, and reloads on reaching 0. div=0 gives a half-period of 1 cycle.

## Timing
- Reset values: gnt0=gnt1=0, SD_n_CS=1, SD_CK=0, SD_DI=1, busy=0, done0=done1=0, rx0=rx1=0x00, arbiter state IDLE.
- Grant latency: reqN high in IDLE at cycle t gives gntN=1 at t+1.
- Byte timing, with start at cycle t and half-period h=div+1:
  - SD_DI=bit7 and busy=1 at t+1.
  - First SD_CK rise at t+1+h.
  - doneN=1 at t+1+16h.
  - Fast default: done at t+33. Slow default: done at t+1025.
- Back-to-back bytes: a start in the done cycle is accepted, because busy is already 0. Minimum byte spacing is 16h+1 cycles.
- Simultaneous events:
  - Both reqs rising in the same IDLE cycle: the tie rule applies.
  - start together with req drop: the start is accepted and the byte completes before release.
- reset mid-byte: all outputs take their reset values immediately; the partial byte is discarded and no done pulse is issued.

## Test plan
- Reset with req1=1: SD_n_CS=1, SD_CK=0, SD_DI=1. After reset release, gnt1=1 on the next cycle and gnt0 stays 0.
- Both reqs high from IDLE: gnt0 first. Drop req0: one IDLE cycle, then gnt1. Drop req1 and re-raise both: gnt0 again.
- Port 0, fast, tx=0xA5, SD_DO loopback from SD_DI: 8 SD_CK pulses of 4-cycle period, done0 at start+33, rx0=0xA5.
- Port 1, slow, tx=0xFF, SD_DO held 0: rising edges every 128 cycles, done1 at start+1025, rx1=0x00.
- start1 while gnt0=1, and start0 while busy: both ignored; busy, SD_CK and rx are unchanged.
- Assert reset 10 cycles into a fast byte: busy=0, SD_CK=0, SD_n_CS=1 immediately, and no done pulse.
